// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared state encoding and counter width for count_monitor.
package count_monitor_pkg;
  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;
  localparam int CNT_W = 8;
endpackage

// File: rtl/count_monitor_if.sv
// count_monitor_if: sample stream in, lock/error status out; err_clr/err_sticky exist only with COUNT_MONITOR_STICKY_ERR_EN.
interface count_monitor_if
  import count_monitor_pkg::*;
#(
  parameter int W = 4
);
  logic [W-1:0] count_in;
  logic count_valid;
  logic locked;
  logic err;
  logic wrap;
  logic [CNT_W-1:0] wrap_cnt;
  logic [CNT_W-1:0] err_cnt;
`ifdef COUNT_MONITOR_STICKY_ERR_EN
  logic err_clr;
  logic err_sticky;
  modport master (output count_in, count_valid, err_clr, input locked, err, wrap, wrap_cnt, err_cnt, err_sticky);
  modport slave (input count_in, count_valid, err_clr, output locked, err, wrap, wrap_cnt, err_cnt, err_sticky);
`else
  modport master (output count_in, count_valid, input locked, err, wrap, wrap_cnt, err_cnt);
  modport slave (input count_in, count_valid, output locked, err, wrap, wrap_cnt, err_cnt);
`endif
endinterface

// File: rtl/count_monitor_sat_counter.sv
// sat_counter: incrementer that sticks at all-ones, with synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= clr ? '0 : (inc && cnt != '1) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/count_monitor.sv
// count_monitor: checks a mod-MOD counter stream, locks after LOCK_LEN good steps, flags errors and wraps.
// Optional COUNT_MONITOR_STICKY_ERR_EN adds err_clr/err_sticky.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int MOD = 4,
  parameter int W = 4,
  parameter int LOCK_LEN = 2
) (
  input logic clk,
  input logic rst,
  count_monitor_if.slave bus
);
  localparam logic [W-1:0] LAST = W'(MOD - 1);
  localparam logic [2:0] LL = 3'(LOCK_LEN);
  state_t state, nxt;
  logic [W-1:0] prev, exp_v;
  logic [2:0] run, run_n, run_inc;
  logic in_rng, match, err_n, wrap_n;
  always_comb begin
    in_rng = bus.count_in <= LAST;
    exp_v = (prev == LAST) ? '0 : prev + 1'b1;
    match = in_rng && bus.count_in == exp_v;
    run_inc = run + 3'd1;
    nxt = !bus.count_valid ? state :
          !in_rng ? IDLE :
          (!match || state == IDLE) ? ACQ :
          (state == LOCK || run_inc == LL) ? LOCK : ACQ;
    run_n = !bus.count_valid ? run : (match && state == ACQ) ? run_inc : '0;
    err_n = bus.count_valid && state == LOCK && !match;
    wrap_n = bus.count_valid && state == LOCK && match && prev == LAST;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      prev <= '0;
      run <= '0;
      bus.locked <= 1'b0;
      bus.err <= 1'b0;
      bus.wrap <= 1'b0;
      bus.wrap_cnt <= '0;
    end else begin
      state <= nxt;
      prev <= bus.count_valid ? bus.count_in : prev;
      run <= run_n;
      bus.locked <= nxt == LOCK;
      bus.err <= err_n;
      bus.wrap <= wrap_n;
      bus.wrap_cnt <= bus.wrap_cnt + CNT_W'(wrap_n);
    end
  sat_counter #(.W(CNT_W)) u_err_cnt (.clk(clk), .clr(rst), .inc(err_n), .cnt(bus.err_cnt));
`ifdef COUNT_MONITOR_STICKY_ERR_EN
  // a new error outranks a simultaneous clear
  always_ff @(posedge clk)
    bus.err_sticky <= rst ? 1'b0 : err_n ? 1'b1 : bus.err_clr ? 1'b0 : bus.err_sticky;
`endif
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: vector table, directed corner sequences and randomized stream against a sample-history model.
module tb_count_monitor;
  localparam int MOD = 4;
  localparam int W = 4;
  localparam int LOCK_LEN = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  count_monitor_if #(.W(W)) bus ();
  count_monitor #(.MOD(MOD), .W(W), .LOCK_LEN(LOCK_LEN)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int m_prev, m_streak, m_wc, m_ec;
  bit m_seed, m_lock, m_err, m_wrap, m_sticky;
  typedef struct {
    bit v;
    int s;
    bit lk;
    bit er;
    bit wr;
    int wc;
    int ec;
  } vec_t;
  vec_t tbl [19];
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic model(bit r, bit v, int s, bit clr);
    m_err = 0;
    m_wrap = 0;
    if (r) begin
      m_prev = 0; m_streak = 0; m_wc = 0; m_ec = 0;
      m_seed = 0; m_lock = 0; m_sticky = 0;
      return;
    end
    if (v) begin
      if (s >= MOD) begin
        m_err = m_lock; m_seed = 0; m_lock = 0; m_streak = 0;
      end else if (!m_seed) begin
        m_seed = 1; m_streak = 0;
      end else if (s == (m_prev + 1) % MOD) begin
        m_wrap = m_lock && m_prev == MOD - 1;
        m_streak++;
        if (m_streak >= LOCK_LEN) m_lock = 1;
      end else begin
        m_err = m_lock; m_lock = 0; m_streak = 0;
      end
      m_prev = s;
    end
    if (m_wrap) m_wc = (m_wc + 1) % 256;
    if (m_err && m_ec < 255) m_ec++;
    m_sticky = m_err ? 1'b1 : clr ? 1'b0 : m_sticky;
  endtask
  task automatic step(bit r, bit v, int s, bit clr);
    @(negedge clk);
    rst = r;
    bus.count_valid = v;
    bus.count_in = W'(s);
`ifdef COUNT_MONITOR_STICKY_ERR_EN
    bus.err_clr = clr;
`endif
    @(posedge clk);
    #1;
    model(r, v, s, clr);
    chk("locked", 32'(bus.locked), 32'(m_lock));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("wrap", 32'(bus.wrap), 32'(m_wrap));
    chk("wrap_cnt", 32'(bus.wrap_cnt), m_wc);
    chk("err_cnt", 32'(bus.err_cnt), m_ec);
`ifdef COUNT_MONITOR_STICKY_ERR_EN
    chk("err_sticky", 32'(bus.err_sticky), 32'(m_sticky));
`endif
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int p;
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 2, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 3, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 0, 1, 1, 0};
    tbl[5]  = '{1, 1, 1, 0, 0, 1, 0};
    tbl[6]  = '{1, 2, 1, 0, 0, 1, 0};
    tbl[7]  = '{1, 3, 1, 0, 0, 1, 0};
    tbl[8]  = '{1, 0, 1, 0, 1, 2, 0};
    tbl[9]  = '{1, 1, 1, 0, 0, 2, 0};
    tbl[10] = '{1, 3, 0, 1, 0, 2, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 2, 1};
    tbl[12] = '{1, 1, 1, 0, 0, 2, 1};
    tbl[13] = '{1, 2, 1, 0, 0, 2, 1};
    tbl[14] = '{1, 5, 0, 1, 0, 2, 2};
    tbl[15] = '{1, 7, 0, 0, 0, 2, 2};
    tbl[16] = '{1, 0, 0, 0, 0, 2, 2};
    tbl[17] = '{1, 1, 0, 0, 0, 2, 2};
    tbl[18] = '{1, 2, 1, 0, 0, 2, 2};
    bus.count_valid = 1'b0;
    bus.count_in = '0;
`ifdef COUNT_MONITOR_STICKY_ERR_EN
    bus.err_clr = 1'b0;
`endif
    step(1, 1, 3, 0);
    step(1, 0, 0, 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 0);
    for (int i = 0; i < 19; i++) begin
      step(0, tbl[i].v, tbl[i].s, 0);
      chk($sformatf("tbl%0d_locked", i), 32'(bus.locked), 32'(tbl[i].lk));
      chk($sformatf("tbl%0d_err", i), 32'(bus.err), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_wrap", i), 32'(bus.wrap), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_wrap_cnt", i), 32'(bus.wrap_cnt), tbl[i].wc);
      chk($sformatf("tbl%0d_err_cnt", i), 32'(bus.err_cnt), tbl[i].ec);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, $urandom_range(0, 15), 0);
      chk("idle_gap_locked", 32'(bus.locked), 1);
      chk("idle_gap_err", 32'(bus.err), 0);
    end
    step(0, 1, 3, 0);
    chk("resume_locked", 32'(bus.locked), 1);
    chk("resume_err", 32'(bus.err), 0);
`ifdef COUNT_MONITOR_STICKY_ERR_EN
    chk("sticky_held", 32'(bus.err_sticky), 1);
    step(0, 0, 0, 1);
    chk("sticky_clr", 32'(bus.err_sticky), 0);
    step(0, 1, 3, 1);
    chk("sticky_set_wins", 32'(bus.err_sticky), 1);
    step(0, 0, 0, 1);
    chk("sticky_clr2", 32'(bus.err_sticky), 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
`endif
    chk("pre_rst_locked", 32'(bus.locked), 1);
    step(1, 1, (m_prev + 1) % MOD, 0);
    chk("midlock_rst_locked", 32'(bus.locked), 0);
    chk("midlock_rst_err", 32'(bus.err), 0);
    chk("midlock_rst_wrap_cnt", 32'(bus.wrap_cnt), 0);
    chk("midlock_rst_err_cnt", 32'(bus.err_cnt), 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    p = 2;
    for (int i = 0; i < 300; i++) begin
      step(0, 1, p, 0);
      step(0, 1, (p + 1) % MOD, 0);
      step(0, 1, (p + 2) % MOD, 0);
      p = (p + 2) % MOD;
    end
    chk("err_cnt_sat", 32'(bus.err_cnt), 255);
`ifdef COUNT_MONITOR_STICKY_ERR_EN
    chk("sticky_after_storm", 32'(bus.err_sticky), 1);
    step(0, 0, 0, 1);
    chk("sticky_after_clr", 32'(bus.err_sticky), 0);
`endif
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    for (int i = 1; i <= 1030; i++) step(0, 1, (2 + i) % MOD, 0);
    chk("wrap_cnt_rollover", 32'(bus.wrap_cnt), 2);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 9) < 7) ? (m_prev + 1) % MOD : int'($urandom_range(0, 7)),
           $urandom_range(0, 15) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 The block SHALL have parameter MOD, default 4: modulus of the monitored counter; legal values 2..16.
REQ-002 The block SHALL have parameter W, default 4: width of the monitored count bus; 2**W >= MOD.
REQ-003 The block SHALL have parameter LOCK_LEN, default 2: consecutive correct increments required to lock; legal values 1..7.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst  input  1: reset; synchronous, active-high.
REQ-006 count_in  input  W: count value from the upstream mod-MOD synchronous counter.
REQ-007 count_valid  input  1: count_in is sampled only on cycles where this is high.
REQ-008 locked  output  1: high while the monitor is tracking a correct sequence.
REQ-009 err  output  1: one-cycle pulse on a sequence violation detected while locked.
REQ-010 wrap  output  1: one-cycle pulse on each observed MOD-1 -> 0 transition while locked.
REQ-011 wrap_cnt  output  8: count of wrap pulses; modulo 256.
REQ-012 err_cnt  output  8: count of err pulses; saturates at 255.

Function
REQ-013 The FSM SHALL have states IDLE, ACQ and LOCK, and SHALL update only on cycles with count_valid=1.
REQ-014 IDLE: in-range sample (< MOD) -> store as prev, run=0, go to ACQ; out-of-range sample -> stay in IDLE.
REQ-015 Expected value SHALL be prev+1, or 0 when prev = MOD-1.
REQ-016 ACQ: sample = expected -> run+1; when run reaches LOCK_LEN -> go to LOCK; mismatch -> reseed prev, run=0, stay in ACQ; out-of-range -> go to IDLE.
REQ-017 LOCK: sample = expected -> stay in LOCK; wrap pulses if prev = MOD-1.
REQ-018 LOCK: mismatch or out-of-range -> err pulse, err_cnt+1, go to ACQ reseeded (in-range) or to IDLE (out-of-range).
REQ-019 Every sample SHALL update prev.
REQ-020 All outputs SHALL be registered, asserting on the cycle after the valid sample that causes them.
REQ-021 A sample equal to prev (stall) SHALL count as a mismatch.
REQ-022 count_valid=0 SHALL hold all state, and err and wrap SHALL be 0 on that cycle.
REQ-023 wrap_cnt SHALL roll over from 255 to 0; err_cnt SHALL hold at 255.
REQ-024 locked SHALL be high exactly while the state is LOCK.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, prev=0, run=0, locked=0, err=0, wrap=0, wrap_cnt=0, err_cnt=0.
REQ-026 rst SHALL take priority over count_valid, and an assertion mid-sequence SHALL discard lock with no err pulse.

Configuration
REQ-027 With COUNT_MONITOR_STICKY_ERR_EN defined, the block SHALL add input err_clr and output err_sticky.
REQ-028 With the macro defined, err_sticky SHALL be set by any err pulse, cleared by err_clr or rst, and set SHALL win when set and clear coincide.
REQ-029 Without COUNT_MONITOR_STICKY_ERR_EN, neither port nor its logic SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Package count_monitor_pkg SHALL hold the state enum (IDLE, ACQ, LOCK) and the 8-bit counter width constant.
REQ-031 err_cnt SHALL be built as one sub-module, sat_counter: an 8-bit saturating incrementer with synchronous clear.

Verification
REQ-032 Bench SHALL cover: rst, then valid stream 0,1,2 (MOD=4, LOCK_LEN=2) -> locked=1 the cycle after sample 2.
REQ-033 Bench SHALL cover: locked, stream 2,3,0,1,2,3,0 -> two wrap pulses, wrap_cnt=2, err=0.
REQ-034 Bench SHALL cover: locked at prev=1, sample 3 -> err pulse, err_cnt=1, locked=0, then 0,1 -> relock.
REQ-035 Bench SHALL cover: sample 5 with MOD=4 while locked -> err pulse, IDLE, and a further 7 is ignored.
REQ-036 Bench SHALL cover: count_valid low 10 cycles mid-lock, then resume with the expected value -> no err, locked held.
REQ-037 Bench SHALL cover: rst mid-lock, then 300 forced errors -> err_cnt=255; with the macro, err_sticky=1 until err_clr.
